// File: rtl/fsm_timeout_example_pkg.sv
// Shared helpers for the parametrised ring FSM examples.
// Width calculation, ring-wrap arithmetic and a/b request codes.
package fsm_example_pkg;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] NEXT = 2'b01;
    localparam logic [1:0] PREV = 2'b10;
    localparam logic [1:0] LAST = 2'b11;

    // Never narrower than one bit, so a 1-valued range still has a vector.
    function automatic int st_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int ring_next(input int s, input int n);
        return (s >= n - 1) ? 0 : s + 1;
    endfunction

    function automatic int ring_prev(input int s, input int n);
        return (s <= 0) ? n - 1 : s - 1;
    endfunction

endpackage

// File: rtl/fsm_timeout_example_if.sv
// Control/status bundle of the ring FSM.
// The master side drives en/a/b; the slave side returns state and pulses.
interface fsm_timeout_example_if #(
    parameter int STATE_CNT  = 3,
    parameter int DOUT_WIDTH = 3
) ();
    import fsm_example_pkg::*;

    localparam int SW = st_w(STATE_CNT);

    logic                  en;
    logic                  a;
    logic                  b;
    logic [DOUT_WIDTH-1:0] dout;
    logic [SW-1:0]         st_o;
    logic                  changed;
    logic                  timeout;

    modport master (
        output en, a, b,
        input  dout, st_o, changed, timeout
    );

    modport slave (
        input  en, a, b,
        output dout, st_o, changed, timeout
    );

endinterface

// File: rtl/fsm_timeout_example_dwell_timer.sv
// Dwell counter of the ring FSM.
// tc flags the last hold cycle before a forced return to state 0.
module fsm_dwell_timer
    import fsm_example_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = st_w(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (clr) begin
                cnt <= '0;
            end else if (inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fsm_timeout_example.sv
// Parametrised ring FSM driven by a/b, with a dwell timeout to state 0.
// Holds state register, next-state decode and the change/timeout pulses.
module fsm_timeout_example
    import fsm_example_pkg::*;
#(
    parameter int STATE_CNT  = 3,
    parameter int DOUT_WIDTH = 3,
    parameter int TIMEOUT    = 15
) (
    input logic                 clk,
    input logic                 rst,
    fsm_timeout_example_if.slave bus
);

    localparam int SW = st_w(STATE_CNT);

    if (STATE_CNT < 3) begin : g_bad_cnt
        $error("STATE_CNT must be at least 3");
    end
    if (STATE_CNT >= (1 << DOUT_WIDTH)) begin : g_bad_dout
        $error("DOUT_WIDTH too narrow to hold STATE_CNT");
    end
    if (TIMEOUT < 2) begin : g_bad_to
        $error("TIMEOUT must be at least 2");
    end

    logic [SW-1:0] st;
    logic [SW-1:0] st_req;
    logic [SW-1:0] st_nx;
    logic [1:0]    req;
    logic          legal;
    logic          idle;
    logic          tc;
    logic          to_fire;
    logic          moved;
    logic          changed_q;
    logic          timeout_q;

    assign req   = {bus.a, bus.b};
    assign legal = (int'(st) < STATE_CNT);
    assign idle  = (st == '0);

    always_comb begin
        st_req = st;
        unique case (1'b1)
            (req == NEXT): st_req = SW'(ring_next(int'(st), STATE_CNT));
            (req == PREV): st_req = SW'(ring_prev(int'(st), STATE_CNT));
            (req == LAST): st_req = SW'(STATE_CNT - 1);
            default:       st_req = st;
        endcase
    end

    // A real request always wins over the dwell timer.
    assign to_fire = legal && !idle && (req == HOLD) && tc;

    always_comb begin
        st_nx = st_req;
        if (!legal || to_fire) begin
            st_nx = '0;
        end
    end

    assign moved = (st_nx != st);

    fsm_dwell_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (bus.en),
        .clr (moved || idle),
        .inc (!moved && !idle),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= '0;
            changed_q <= 1'b0;
            timeout_q <= 1'b0;
        end else if (bus.en) begin
            st        <= st_nx;
            changed_q <= moved;
            timeout_q <= to_fire;
        end else begin
            changed_q <= 1'b0;
            timeout_q <= 1'b0;
        end
    end

    assign bus.st_o    = st;
    assign bus.dout    = DOUT_WIDTH'(st) + DOUT_WIDTH'(1);
    assign bus.changed = changed_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_fsm_timeout_example.sv
// Directed bench for the ring FSM: step, wrap, timeout, priority,
// enable freeze, async reset and a five-state build.
module tb_fsm_timeout_example;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fsm_timeout_example_if #(.STATE_CNT(3), .DOUT_WIDTH(3)) bus ();
    fsm_timeout_example_if #(.STATE_CNT(5), .DOUT_WIDTH(3)) bus5 ();

    fsm_timeout_example #(
        .STATE_CNT  (3),
        .DOUT_WIDTH (3),
        .TIMEOUT    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fsm_timeout_example #(
        .STATE_CNT  (5),
        .DOUT_WIDTH (3),
        .TIMEOUT    (4)
    ) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic a, input logic b);
        bus.en = en;
        bus.a  = a;
        bus.b  = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        bus5.en = 1'b0;
        bus5.a  = 1'b0;
        bus5.b  = 1'b0;
        #3;
        checks++;
        if (bus.st_o !== 2'd0 || bus.dout !== 3'd1 ||
            bus.changed !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: st=%0d dout=%0d ch=%0b to=%0b want 0 1 0 0",
                     bus.st_o, bus.dout, bus.changed, bus.timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        step();
        checks++;
        if (bus.st_o !== 2'd1 || bus.dout !== 3'd2 || bus.changed !== 1'b1) begin
            errors++;
            $display("FAIL step: st=%0d dout=%0d ch=%0b want 1 2 1",
                     bus.st_o, bus.dout, bus.changed);
        end
        drive(1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.st_o !== 2'd1 || bus.changed !== 1'b0) begin
            errors++;
            $display("FAIL step_hold: st=%0d ch=%0b want 1 0",
                     bus.st_o, bus.changed);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if (bus.st_o !== 2'd2 || bus.dout !== 3'd3 || bus.changed !== 1'b1) begin
            errors++;
            $display("FAIL wrap_prev: st=%0d dout=%0d ch=%0b want 2 3 1",
                     bus.st_o, bus.dout, bus.changed);
        end
        drive(1'b1, 1'b0, 1'b1);
        step();
        checks++;
        if (bus.st_o !== 2'd0 || bus.dout !== 3'd1 || bus.changed !== 1'b1) begin
            errors++;
            $display("FAIL wrap_next: st=%0d dout=%0d ch=%0b want 0 1 1",
                     bus.st_o, bus.dout, bus.changed);
        end
        drive(1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (bus.st_o !== 2'd2 || bus.changed !== 1'b1) begin
            errors++;
            $display("FAIL last1: st=%0d ch=%0b want 2 1",
                     bus.st_o, bus.changed);
        end
        step();
        checks++;
        if (bus.st_o !== 2'd2 || bus.changed !== 1'b0) begin
            errors++;
            $display("FAIL last2: st=%0d ch=%0b want 2 0",
                     bus.st_o, bus.changed);
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (dut.u_timer.cnt !== 2'(i) || bus.st_o !== 2'd1 ||
                bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL dwell_%0d: cnt=%0d st=%0d to=%0b want %0d 1 0",
                         i, dut.u_timer.cnt, bus.st_o, bus.timeout, i);
            end
        end
        step();
        checks++;
        if (bus.st_o !== 2'd0 || bus.timeout !== 1'b1 || bus.changed !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: st=%0d to=%0b ch=%0b want 0 1 1",
                     bus.st_o, bus.timeout, bus.changed);
        end
        step();
        checks++;
        if (bus.timeout !== 1'b0 || bus.changed !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: to=%0b ch=%0b want 0 0",
                     bus.timeout, bus.changed);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.timeout !== 1'b0 || bus.st_o !== 2'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_s0: bad cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_priority();
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0);
        step();
        step();
        step();
        checks++;
        if (dut.u_timer.cnt !== 2'd3) begin
            errors++;
            $display("FAIL prio_cnt: cnt=%0d want 3", dut.u_timer.cnt);
        end
        drive(1'b1, 1'b0, 1'b1);
        step();
        checks++;
        if (bus.st_o !== 2'd2 || bus.timeout !== 1'b0 ||
            bus.changed !== 1'b1 || dut.u_timer.cnt !== 2'd0) begin
            errors++;
            $display("FAIL priority: st=%0d to=%0b ch=%0b cnt=%0d want 2 0 1 0",
                     bus.st_o, bus.timeout, bus.changed, dut.u_timer.cnt);
        end
    endtask

    task automatic test_enable();
        int bad;
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0);
        step();
        step();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'(i), 1'(i + 1));
            step();
            if (bus.st_o !== 2'd1 || dut.u_timer.cnt !== 2'd2 ||
                bus.changed !== 1'b0 || bus.timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL freeze: bad cycles=%0d want 0", bad);
        end
        drive(1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.st_o !== 2'd1 || bus.timeout !== 1'b0 ||
            dut.u_timer.cnt !== 2'd3) begin
            errors++;
            $display("FAIL resume1: st=%0d to=%0b cnt=%0d want 1 0 3",
                     bus.st_o, bus.timeout, dut.u_timer.cnt);
        end
        step();
        checks++;
        if (bus.st_o !== 2'd0 || bus.timeout !== 1'b1) begin
            errors++;
            $display("FAIL resume2: st=%0d to=%0b want 0 1",
                     bus.st_o, bus.timeout);
        end
    endtask

    task automatic test_async_mid();
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0);
        step();
        step();
        step();
        checks++;
        if (bus.st_o !== 2'd2 || dut.u_timer.cnt !== 2'd3) begin
            errors++;
            $display("FAIL pre_rst: st=%0d cnt=%0d want 2 3",
                     bus.st_o, dut.u_timer.cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.st_o !== 2'd0 || bus.dout !== 3'd1 || bus.changed !== 1'b0 ||
            bus.timeout !== 1'b0 || dut.u_timer.cnt !== 2'd0) begin
            errors++;
            $display("FAIL async_rst: st=%0d dout=%0d ch=%0b to=%0b cnt=%0d want 0 1 0 0 0",
                     bus.st_o, bus.dout, bus.changed, bus.timeout, dut.u_timer.cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_five();
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        bus5.en = 1'b1;
        bus5.a  = 1'b1;
        bus5.b  = 1'b1;
        step();
        checks++;
        if (bus5.st_o !== 3'd4 || bus5.dout !== 3'd5 || bus5.changed !== 1'b1) begin
            errors++;
            $display("FAIL five_last: st=%0d dout=%0d ch=%0b want 4 5 1",
                     bus5.st_o, bus5.dout, bus5.changed);
        end
        bus5.a = 1'b0;
        bus5.b = 1'b1;
        step();
        checks++;
        if (bus5.st_o !== 3'd0 || bus5.dout !== 3'd1) begin
            errors++;
            $display("FAIL five_wrap: st=%0d dout=%0d want 0 1",
                     bus5.st_o, bus5.dout);
        end
        step();
        step();
        checks++;
        if (bus5.st_o !== 3'd2 || bus5.dout !== 3'd3) begin
            errors++;
            $display("FAIL five_next: st=%0d dout=%0d want 2 3",
                     bus5.st_o, bus5.dout);
        end
        bus5.a = 1'b1;
        bus5.b = 1'b0;
        step();
        checks++;
        if (bus5.st_o !== 3'd1 || bus5.changed !== 1'b1) begin
            errors++;
            $display("FAIL five_prev: st=%0d ch=%0b want 1 1",
                     bus5.st_o, bus5.changed);
        end
        bus5.en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_wrap();
        test_timeout();
        test_priority();
        test_enable();
        test_async_mid();
        test_five();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
